db_req_hash: RTL
================

Name: db_req_hash

Overview:
- Request front-end that sits directly upstream of db_cont.
- Accepts key/value commands from the packet parser and computes the 32-bit bucket hash of the key with a pipelined CRC-32.
- Buffers completed commands in a small FIFO and issues them to db_cont as single-cycle in_valid pulses. Issues are spaced by a programmable minimum gap, because db_cont has no backpressure.

Parameters:
KEY_SIZE, 96, key width in bits; must be a multiple of 32 (default key is {src_ip, dst_ip, dst_port, 16'h0}-packed).
HASH_SIZE, 32, hash width; fixed at 32 (CRC-32).
VAL_SIZE, 32, value width.
OP_SIZE, 4, opcode width.
FIFO_DEPTH, 8, output FIFO entries; must be a power of 2, ≥2.
ISSUE_GAP, 6, minimum cycles between consecutive out_valid pulses; ≥1.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  request can be accepted this cycle
req_op  in  OP_SIZE  opcode, passed through uninterpreted
req_key  in  KEY_SIZE  lookup key
req_value  in  VAL_SIZE  value, passed through
out_valid  out  1  one-cycle command strobe to db_cont in_valid
out_op  out  OP_SIZE  to db_cont in_op
out_hash  out  HASH_SIZE  to db_cont in_hash
out_key  out  KEY_SIZE  to db_cont in_key
out_value  out  VAL_SIZE  to db_cont in_value
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst low, asynchronous, effective immediately):
  - Clears pipeline valids, FIFO pointers and gap counter.
  - All out_* go to 0, fifo_level goes to 0, req_ready goes to 0.
  - req_ready rises on the first clock edge after rst is released.
  - In-flight and buffered commands are discarded; no partial command is ever issued.
- Accept: a request is accepted on a rising edge where req_valid && req_ready.
  - req_ready = (FIFO entries + valid pipeline entries) < FIFO_DEPTH, decoded from registers only.
  - This credit rule guarantees the FIFO never overflows.
- Hash:
  - CRC-32, poly 0x04C11DB7, init 0xFFFFFFFF, non-reflected, MSB-first, final XOR 0xFFFFFFFF.
  - Bytes are taken from req_key MSB first (key[KEY_SIZE-1 -: 8] first).
- Pipeline:
  - NSTAGE = KEY_SIZE/32 register stages (3 by default); stage k folds 32-bit key word k, MSB word first.
  - op, key and value travel alongside the CRC.
  - Fully pipelined: throughput one request per cycle.
- FIFO: the last pipeline stage writes into the FIFO on the next edge.
  - Simultaneous write and read in one cycle are allowed, including at full and at empty (no bypass; an entry written at an edge is readable from the next cycle).
  - Pointers wrap modulo FIFO_DEPTH.
- Issue and gap counter:
  - When the FIFO is non-empty and the gap counter is 0, the head entry is popped into the out_* registers and out_valid is high for exactly one cycle.
  - On issue, the gap counter loads ISSUE_GAP-1 and then decrements to 0.
  - ISSUE_GAP=1 allows back-to-back pulses.
- Latency: with the block idle, a request accepted at edge E0 produces out_valid sampled high at edge E0+NSTAGE+2 (edge 5 for the defaults).
- Ordering: commands are issued strictly in acceptance order.
- Hold: out_op, out_hash, out_key and out_value keep their last issued values while out_valid is low.
- A held req_valid while req_ready is low is not accepted and is not duplicated; it is accepted once, on the first edge where req_ready is high.

Test Plan:
1. Single request, key {192.168.10.11, 192.168.80.87, 16'd12345, 16'h0}, op 4'b0011, value 32'hdeadbeef -> exactly one out_valid, 5 edges after accept; out_hash equals the bench CRC model; out_op, out_key and out_value match the request.
2. Burst of 12 back-to-back requests with defaults -> req_ready drops after 8 accepts outstanding; out_valid pulses exactly 6 cycles apart; all 12 issued in order; fifo_level never exceeds 8.
3. Same key issued twice gives an identical out_hash; flipping key bit 0, then key bit 95, gives hashes that differ from it and match the model; all-zero and all-ones keys match the model.
4. ISSUE_GAP=1 build, 20 consecutive requests -> req_ready stays 1; out_valid stays high for 20 consecutive cycles starting at latency 5.
5. rst driven low mid-burst (3 entries in FIFO, 2 in pipeline), between clock edges -> out_valid and fifo_level are 0 before the next edge; after release, no stale command is issued and a new request behaves as in test 1.
6. req_valid held high with op 4'b0101 while req_ready is low -> no acceptance until req_ready rises; exactly one matching out_valid follows.

Source files
------------

// File: rtl/db_req_hash.sv
// db_req_hash: request front-end for db_cont.
// Accepts key/value commands and hashes each key with a pipelined CRC-32.
// Finished commands are buffered in a small FIFO. They are then issued to db_cont
// as single-cycle out_valid pulses, with at least ISSUE_GAP cycles between pulses.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   req_valid/ready    request handshake (accepted when both are high at an edge)
//   req_op/key/value   command fields; op and value pass through untouched
//   out_valid          one-cycle strobe to db_cont in_valid
//   out_op/hash/key/value  command fields, held between strobes
//   fifo_level         current FIFO occupancy
module db_req_hash #(
  parameter int KEY_SIZE   = 96,
  parameter int HASH_SIZE  = 32,
  parameter int VAL_SIZE   = 32,
  parameter int OP_SIZE    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ISSUE_GAP  = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [OP_SIZE-1:0]            req_op,
  input  logic [KEY_SIZE-1:0]           req_key,
  input  logic [VAL_SIZE-1:0]           req_value,
  output logic                          out_valid,
  output logic [OP_SIZE-1:0]            out_op,
  output logic [HASH_SIZE-1:0]          out_hash,
  output logic [KEY_SIZE-1:0]           out_key,
  output logic [VAL_SIZE-1:0]           out_value,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int NSTAGE = KEY_SIZE / 32;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int GW     = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  // Fold one 32-bit word into the running CRC, MSB first (non-reflected).
  function automatic logic [31:0] crcFold(input logic [31:0] crcIn, input logic [31:0] word);
    logic [31:0] c;
    logic        fb;
    c = crcIn;
    for (int i = 31; i >= 0; i--) begin
      fb = c[31] ^ word[i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ 32'h04C11DB7;
    end
    return c;
  endfunction

  logic [NSTAGE-1:0]   stValid_q;
  logic [31:0]         stCrc_q   [NSTAGE];
  logic [OP_SIZE-1:0]  stOp_q    [NSTAGE];
  logic [KEY_SIZE-1:0] stKey_q   [NSTAGE];
  logic [VAL_SIZE-1:0] stValue_q [NSTAGE];

  logic [OP_SIZE-1:0]   memOp    [FIFO_DEPTH];
  logic [HASH_SIZE-1:0] memHash  [FIFO_DEPTH];
  logic [KEY_SIZE-1:0]  memKey   [FIFO_DEPTH];
  logic [VAL_SIZE-1:0]  memValue [FIFO_DEPTH];

  logic [AW:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [GW-1:0] gapCnt_q, gapCnt_d;
  logic          armed_q;
  logic          accept, push, issue;
  logic [AW:0]   level;
  logic [31:0]   occupancy;

  // Credits count both buffered entries and commands still in the hash pipeline.
  // This means every accepted request is guaranteed a FIFO slot.
  // The decode uses registers only, so req_ready has no path from req_valid.
  always_comb begin
    level     = wrPtr_q - rdPtr_q;
    occupancy = 32'(level);
    for (int k = 0; k < NSTAGE; k++) begin
      occupancy = occupancy + 32'(stValid_q[k]);
    end
    req_ready = armed_q && (occupancy < 32'(FIFO_DEPTH));
    accept    = req_valid && req_ready;
    push      = stValid_q[NSTAGE-1];
    issue     = (level != '0) && (gapCnt_q == '0);
  end

  always_comb begin
    wrPtr_d  = push  ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d  = issue ? rdPtr_q + 1'b1 : rdPtr_q;
    gapCnt_d = gapCnt_q;
    if (issue) begin
      gapCnt_d = GW'(ISSUE_GAP - 1);
    end else if (gapCnt_q != '0) begin
      gapCnt_d = gapCnt_q - GW'(1);
    end
  end

  assign fifo_level = level;

  // armed_q keeps req_ready low until the first edge after reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q   <= 1'b0;
      stValid_q <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      gapCnt_q  <= '0;
    end else begin
      armed_q   <= 1'b1;
      stValid_q <= (stValid_q << 1) | NSTAGE'(accept);
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      gapCnt_q  <= gapCnt_d;
    end
  end

  // Pipeline datapath: stage k folds key word k, starting with the most significant word.
  // Data registers are not reset because only stValid_q qualifies them.
  always_ff @(posedge clk) begin
    stCrc_q[0]   <= crcFold(32'hFFFFFFFF, req_key[KEY_SIZE-1 -: 32]);
    stOp_q[0]    <= req_op;
    stKey_q[0]   <= req_key;
    stValue_q[0] <= req_value;
    for (int k = 1; k < NSTAGE; k++) begin
      stCrc_q[k]   <= crcFold(stCrc_q[k-1], stKey_q[k-1][KEY_SIZE-1-32*k -: 32]);
      stOp_q[k]    <= stOp_q[k-1];
      stKey_q[k]   <= stKey_q[k-1];
      stValue_q[k] <= stValue_q[k-1];
    end
  end

  // The final XOR is applied as the finished command is written into the FIFO.
  always_ff @(posedge clk) begin
    if (push) begin
      memOp[wrPtr_q[AW-1:0]]    <= stOp_q[NSTAGE-1];
      memHash[wrPtr_q[AW-1:0]]  <= HASH_SIZE'(~stCrc_q[NSTAGE-1]);
      memKey[wrPtr_q[AW-1:0]]   <= stKey_q[NSTAGE-1];
      memValue[wrPtr_q[AW-1:0]] <= stValue_q[NSTAGE-1];
    end
  end

  // Output registers hold the last issued command while out_valid is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_hash  <= '0;
      out_key   <= '0;
      out_value <= '0;
    end else begin
      out_valid <= issue;
      if (issue) begin
        out_op    <= memOp[rdPtr_q[AW-1:0]];
        out_hash  <= memHash[rdPtr_q[AW-1:0]];
        out_key   <= memKey[rdPtr_q[AW-1:0]];
        out_value <= memValue[rdPtr_q[AW-1:0]];
      end
    end
  end

endmodule
